// File: rtl/proc_fetch_ctrl.sv
// Instruction fetch controller: BUBBLE/FETCH/HOLD sequencing with branch/jump redirects.
// Optional exception redirect to EXC_VEC is enabled by defining PROC_FETCH_EXC_EN.
module proc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp_en,
   input  logic [31:0] jmp_target,
   input  logic        exc_req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      BUBBLE = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t      state;
   logic        redirect;
   logic [31:0] redirect_target;

   assign imem_addr = pc;

   // Redirect selection: exception (when built in) over branch over jump.
`ifdef PROC_FETCH_EXC_EN
   always_comb begin
      redirect        = 1'b0;
      redirect_target = 32'h0000_0000;
      if (exc_req) begin
         redirect        = 1'b1;
         redirect_target = EXC_VEC;
      end else if (br_taken) begin
         redirect        = 1'b1;
         redirect_target = br_target;
      end else if (jmp_en) begin
         redirect        = 1'b1;
         redirect_target = jmp_target;
      end else begin
         redirect        = 1'b0;
         redirect_target = 32'h0000_0000;
      end
   end
`else
   // Exception input and vector are deliberately left dangling in this build.
   logic [31:0] unused_exc;
   assign unused_exc = EXC_VEC ^ {31'd0, exc_req};

   always_comb begin
      redirect        = 1'b0;
      redirect_target = 32'h0000_0000;
      if (br_taken) begin
         redirect        = 1'b1;
         redirect_target = br_target;
      end else if (jmp_en) begin
         redirect        = 1'b1;
         redirect_target = jmp_target;
      end else begin
         redirect        = 1'b0;
         redirect_target = 32'h0000_0000;
      end
   end
`endif

   // Fetch FSM; redirects squash any ack or held instruction in the same cycle.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state    <= BUBBLE;
         pc       <= RESET_PC;
         imem_req <= 1'b0;
         if_valid <= 1'b0;
         if_instr <= 32'h0000_0000;
         if_pc    <= 32'h0000_0000;
      end else if (redirect) begin
         state    <= BUBBLE;
         pc       <= {redirect_target[31:2], 2'b00};
         imem_req <= 1'b0;
         if_valid <= 1'b0;
      end else begin
         case (state)
            BUBBLE: begin
               state    <= FETCH;
               imem_req <= 1'b1;
               if_valid <= 1'b0;
            end
            FETCH: begin
               if (imem_ack) begin
                  if_instr <= imem_rdata;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  pc       <= pc + 32'd4;
                  if (stall) begin
                     state    <= HOLD;
                     imem_req <= 1'b0;
                  end else begin
                     state    <= FETCH;
                     imem_req <= 1'b1;
                  end
               end else begin
                  if_valid <= 1'b0;
                  imem_req <= 1'b1;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
                  if_valid <= 1'b0;
               end else begin
                  state    <= HOLD;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= BUBBLE;
               imem_req <= 1'b0;
               if_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_fetch_ctrl.sv
// Bench for proc_fetch_ctrl: directed scenarios plus a delivery scoreboard.
module tb_proc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        nrst;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp_en;
   logic [31:0] jmp_target;
   logic        exc_req;
   logic        imem_ack;
   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        if_valid, if_valid2;
   logic [31:0] if_instr, if_instr2;
   logic [31:0] if_pc, if_pc2;
   logic [31:0] pc, pc2;

   int total = 0;
   int bad   = 0;

   logic [63:0] sb[$];
   logic [63:0] sb_exp;
   logic        pending = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   assign imem_rdata  = mem_word(imem_addr);
   assign imem_rdata2 = mem_word(imem_addr2);

   proc_fetch_ctrl dut (
      .clk(clk), .nrst(nrst), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_en(jmp_en), .jmp_target(jmp_target), .exc_req(exc_req),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .pc(pc)
   );

   proc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .nrst(nrst), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_en(jmp_en), .jmp_target(jmp_target), .exc_req(exc_req),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata2),
      .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .pc(pc2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard: an accepted ack pushes {addr, word}; the next cycle must deliver it.
   always @(negedge clk) begin
      if (pending) begin
         sb_exp = sb.pop_front();
         check_eq("sb_valid", {31'd0, if_valid}, 32'd1);
         check_eq("sb_pc", if_pc, sb_exp[63:32]);
         check_eq("sb_instr", if_instr, sb_exp[31:0]);
      end
`ifdef PROC_FETCH_EXC_EN
      pending = (imem_req === 1'b1) && (imem_ack === 1'b1) && (nrst === 1'b0) &&
                (br_taken === 1'b0) && (jmp_en === 1'b0) && (exc_req === 1'b0);
`else
      pending = (imem_req === 1'b1) && (imem_ack === 1'b1) && (nrst === 1'b0) &&
                (br_taken === 1'b0) && (jmp_en === 1'b0);
`endif
      if (pending) sb.push_back({imem_addr, mem_word(imem_addr)});
   end

   initial begin
      nrst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
      jmp_en = 1'b0; jmp_target = 32'd0; exc_req = 1'b0; imem_ack = 1'b0;
      tick(); tick();
      check_eq("rst_pc", pc, 32'h0000_0000);
      check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_req", {31'd0, imem_req}, 32'd0);
      check_eq("rst_instr", if_instr, 32'd0);
      check_eq("rst_ifpc", if_pc, 32'd0);
      check_eq("rst_pc2", pc2, 32'hFFFF_FFF8);

      // Streaming with constant ack
      nrst = 1'b0; imem_ack = 1'b1;
      tick();
      check_eq("s1_req", {31'd0, imem_req}, 32'd1);
      check_eq("s1_addr", imem_addr, 32'h0);
      check_eq("s1_valid", {31'd0, if_valid}, 32'd0);
      check_eq("w1_addr", imem_addr2, 32'hFFFF_FFF8);
      tick();
      check_eq("s2_addr", imem_addr, 32'h4);
      check_eq("s2_valid", {31'd0, if_valid}, 32'd1);
      check_eq("w2_addr", imem_addr2, 32'hFFFF_FFFC);
      tick();
      check_eq("s3_addr", imem_addr, 32'h8);
      check_eq("s3_ifpc", if_pc, 32'h4);
      check_eq("s3_valid", {31'd0, if_valid}, 32'd1);
      check_eq("w3_pc", pc2, 32'h0000_0000);
      check_eq("w3_ifpc", if_pc2, 32'hFFFF_FFFC);

      // Stall on the ack of 0x8 for three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("hold_ifpc", if_pc, 32'h8);
         check_eq("hold_valid", {31'd0, if_valid}, 32'd1);
         check_eq("hold_instr", if_instr, mem_word(32'h8));
         check_eq("hold_pc", pc, 32'hC);
         check_eq("hold_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      tick();
      check_eq("resume_req", {31'd0, imem_req}, 32'd1);
      check_eq("resume_addr", imem_addr, 32'hC);
      check_eq("resume_valid", {31'd0, if_valid}, 32'd0);
      tick();
      check_eq("resume_ifpc", if_pc, 32'hC);

      // Branch in the same cycle as an ack
      br_taken = 1'b1; br_target = 32'h0000_0103;
      tick();
      check_eq("br_pc", pc, 32'h100);
      check_eq("br_valid", {31'd0, if_valid}, 32'd0);
      check_eq("br_req", {31'd0, imem_req}, 32'd0);
      br_taken = 1'b0;
      tick();
      check_eq("br_fetch_addr", imem_addr, 32'h100);
      check_eq("br_fetch_req", {31'd0, imem_req}, 32'd1);
      tick();
      check_eq("br_ifpc", if_pc, 32'h100);

      // Redirect priority
      br_taken = 1'b1; br_target = 32'h200; jmp_en = 1'b1; jmp_target = 32'h300;
      tick();
      check_eq("prio_br", pc, 32'h200);
      exc_req = 1'b1;
      tick();
`ifdef PROC_FETCH_EXC_EN
      check_eq("prio_exc", pc, 32'h80);
`else
      check_eq("prio_exc_off", pc, 32'h200);
`endif
      exc_req = 1'b0; br_taken = 1'b0; jmp_target = 32'h301;
      tick();
      check_eq("jmp_pc", pc, 32'h300);
      jmp_en = 1'b0;
      tick();
      check_eq("jmp_fetch_addr", imem_addr, 32'h300);

      // Redirect squashes a held instruction despite stall
      stall = 1'b1;
      tick();
      check_eq("hold2_ifpc", if_pc, 32'h300);
      br_taken = 1'b1; br_target = 32'h404;
      tick();
      check_eq("sq_pc", pc, 32'h404);
      check_eq("sq_valid", {31'd0, if_valid}, 32'd0);
      br_taken = 1'b0; stall = 1'b0;
      tick();
      tick();
      check_eq("d404_ifpc", if_pc, 32'h404);

      // Ack withheld: pc and req hold, valid drops
      imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("wait_pc", pc, 32'h408);
         check_eq("wait_req", {31'd0, imem_req}, 32'd1);
         check_eq("wait_valid", {31'd0, if_valid}, 32'd0);
      end
      imem_ack = 1'b1;
      tick();
      check_eq("d408_ifpc", if_pc, 32'h408);

      // Reset during an acked fetch
      nrst = 1'b1;
      tick();
      check_eq("mr_valid", {31'd0, if_valid}, 32'd0);
      check_eq("mr_pc", pc, 32'h0);
      check_eq("mr_req", {31'd0, imem_req}, 32'd0);
      nrst = 1'b0; imem_ack = 1'b0;
      tick();
      check_eq("mr_fetch_req", {31'd0, imem_req}, 32'd1);
      check_eq("mr_fetch_addr", imem_addr, 32'h0);
      tick(); tick();
      check_eq("sb_drain", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
